// File: rtl/dsram_pkg.sv
// -----------------------------------------------------------------------------
// dsram_pkg
//   Shared definitions for the data_sram responder:
//     - DSRAM_CONF_BASE : default MMIO base address (upper half selects region)
//     - OFF_LED / OFF_SCRATCH / OFF_TIMER : conf register byte offsets
//     - rd_sel_e        : registered read-data source select
//     - byte_merge()    : merge a new word into an old one under byte enables
// -----------------------------------------------------------------------------
package dsram_pkg;

    localparam logic [31:0] DSRAM_CONF_BASE = 32'hBFAF_0000;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SCRATCH = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;

    typedef enum logic {
        RdSelRam  = 1'b0,
        RdSelConf = 1'b1
    } rd_sel_e;

    // Lane i of the result comes from new_word when wen[i] is set, else old_word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dsram_confreg.sv
// -----------------------------------------------------------------------------
// dsram_confreg
//   MMIO register block behind the data_sram responder: LED (16 bit RW),
//   SCRATCH (32 bit RW) and, when DSRAM_TIMER_EN is defined, a free-running
//   32-bit TIMER (RO). Without DSRAM_TIMER_EN the timer offset reads 0.
//   The read mux is combinational on the current register values; the top
//   level registers it at the request edge, which gives read-first behaviour.
//
//   Ports:
//     clk       in   clock
//     resetn    in   asynchronous active-low reset
//     i_wr      in   conf write strobe (request hits conf region with wen!=0)
//     i_off     in   16-bit byte offset within the conf region
//     i_wdata   in   write data
//     i_wen     in   byte-lane write enables
//     o_rdata   out  read data for i_off (combinational)
//     o_led     out  LED register contents
//
//   Configuration macro: DSRAM_TIMER_EN
// -----------------------------------------------------------------------------
module dsram_confreg
    import dsram_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_wr,
    input  logic [15:0] i_off,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wen,
    output logic [31:0] o_rdata,
    output logic [15:0] o_led
);

    logic [15:0] r_led;
    logic [31:0] r_scratch;
    logic [31:0] w_led_merged;
    logic [31:0] w_scratch_merged;
    logic [31:0] w_rdata;
    logic        w_unused_led_hi;

    assign w_led_merged     = byte_merge({16'h0000, r_led}, i_wdata, i_wen);
    assign w_scratch_merged = byte_merge(r_scratch, i_wdata, i_wen);
    // LED only keeps the low half; lanes 2/3 of a LED write are discarded.
    assign w_unused_led_hi  = ^w_led_merged[31:16];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led     <= 16'h0000;
            r_scratch <= 32'h0000_0000;
        end else if (i_wr) begin
            if (i_off == OFF_LED) begin
                r_led <= w_led_merged[15:0];
            end
            if (i_off == OFF_SCRATCH) begin
                r_scratch <= w_scratch_merged;
            end
        end
    end

`ifdef DSRAM_TIMER_EN
    logic [31:0] r_timer;

    // Free-running; wraps naturally at 2**32. Writes to its offset are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= 32'h0000_0000;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = 32'h0000_0000;
        case (i_off)
            OFF_LED:     w_rdata = {16'h0000, r_led};
            OFF_SCRATCH: w_rdata = r_scratch;
`ifdef DSRAM_TIMER_EN
            OFF_TIMER:   w_rdata = r_timer;
`endif
            default:     w_rdata = 32'h0000_0000;
        endcase
    end

    assign o_rdata = w_rdata;
    assign o_led   = r_led;

endmodule

// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//   Responder for the core's data_sram port. Each access is decoded to either
//   a word-addressed on-chip RAM (2**ADDR_W words, upper index bits alias) or
//   the conf register block (dsram_confreg) when addr[31:16] matches
//   CONF_BASE[31:16]. Read data is registered: a request at edge N is visible
//   on data_sram_rdata after edge N, with read-first semantics for both RAM
//   and conf. No stalls; one access per cycle.
//
//   Ports:
//     clk              in   clock
//     resetn           in   asynchronous active-low reset
//     data_sram_en     in   access request
//     data_sram_wen    in   byte-lane write enables (0 = read)
//     data_sram_addr   in   byte address ([1:0] ignored)
//     data_sram_wdata  in   write data
//     data_sram_rdata  out  registered read data
//     led_out          out  LED register contents
//
//   Configuration macro: DSRAM_TIMER_EN (enables the conf TIMER register)
// -----------------------------------------------------------------------------
module data_sram_resp
    import dsram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] CONF_BASE = DSRAM_CONF_BASE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led_out
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_ram_q;
    logic [31:0]       r_conf_q;
    rd_sel_e           r_rd_sel;

    logic              w_conf_hit;
    logic [ADDR_W-1:0] w_idx;
    logic              w_ram_rd;
    logic              w_ram_wr;
    logic              w_conf_rd;
    logic              w_conf_wr;
    logic [31:0]       w_conf_rdata;

    assign w_conf_hit = data_sram_addr[31:16] == CONF_BASE[31:16];
    assign w_idx      = data_sram_addr[ADDR_W+1:2];
    assign w_ram_rd   = data_sram_en & ~w_conf_hit;
    assign w_ram_wr   = w_ram_rd & (|data_sram_wen);
    assign w_conf_rd  = data_sram_en & w_conf_hit;
    assign w_conf_wr  = w_conf_rd & (|data_sram_wen);

    // RAM array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[w_idx] <= byte_merge(r_mem[w_idx], data_sram_wdata, data_sram_wen);
        end
    end

    // Both read paths sample the pre-write contents at the request edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ram_q  <= 32'h0000_0000;
            r_conf_q <= 32'h0000_0000;
            r_rd_sel <= RdSelRam;
        end else if (data_sram_en) begin
            r_rd_sel <= w_conf_hit ? RdSelConf : RdSelRam;
            if (w_ram_rd) begin
                r_ram_q <= r_mem[w_idx];
            end
            if (w_conf_rd) begin
                r_conf_q <= w_conf_rdata;
            end
        end
    end

    assign data_sram_rdata = (r_rd_sel == RdSelConf) ? r_conf_q : r_ram_q;

    dsram_confreg u_confreg (
        .clk     (clk),
        .resetn  (resetn),
        .i_wr    (w_conf_wr),
        .i_off   (data_sram_addr[15:0]),
        .i_wdata (data_sram_wdata),
        .i_wen   (data_sram_wen),
        .o_rdata (w_conf_rdata),
        .o_led   (led_out)
    );

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//   Directed self-checking bench for data_sram_resp. Inputs change 1 ns after
//   the rising edge; outputs are sampled 1 ns after the edge that consumed the
//   request, where the registered read data has just updated.
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

    localparam logic [31:0] CONF = 32'hBFAF_0000;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led_out;

    int checks;
    int errors;

    data_sram_resp #(
        .ADDR_W    (10),
        .CONF_BASE (CONF)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led_out         (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request, let one edge consume it, land 1 ns after that edge.
    task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wd);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h exp %h", data_sram_rdata, 32'h0);
        end
        checks++;
        if (led_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_led got %h exp %h", led_out, 16'h0);
        end
        resetn = 1'b1;
        idle();
        idle();
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_idle_rdata got %h exp %h", data_sram_rdata, 32'h0);
        end
        // Make 0x10 a known-unwritten-equivalent 0, then read it back.
        cyc(1'b1, 4'b1111, 32'h0000_0010, 32'h0);
        cyc(1'b1, 4'b0000, 32'h0000_0010, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL read_0x10 got %h exp %h", data_sram_rdata, 32'h0);
        end
    endtask

    task automatic test_ram_rw();
        cyc(1'b1, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF);
        cyc(1'b1, 4'b0000, 32'h0000_0040, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_read got %h exp %h", data_sram_rdata, 32'hDEAD_BEEF);
        end
        // Index bits are [11:2]; bit 12 and the low two bits are ignored.
        cyc(1'b1, 4'b0000, 32'h0000_1043, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_alias got %h exp %h", data_sram_rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_byte_lanes();
        cyc(1'b1, 4'b0101, 32'h0000_0040, 32'h1122_3344);
        cyc(1'b1, 4'b0000, 32'h0000_0040, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hDE22_BE44) begin
            errors++;
            $display("FAIL byte_lanes got %h exp %h", data_sram_rdata, 32'hDE22_BE44);
        end
    endtask

    task automatic test_read_first();
        cyc(1'b1, 4'b1111, 32'h0000_0040, 32'hAAAA_5555);
        cyc(1'b1, 4'b1111, 32'h0000_0040, 32'h0000_0000);
        checks++;
        if (data_sram_rdata !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL read_first_old got %h exp %h", data_sram_rdata, 32'hAAAA_5555);
        end
        cyc(1'b1, 4'b0000, 32'h0000_0040, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL read_first_new got %h exp %h", data_sram_rdata, 32'h0);
        end
    endtask

    task automatic test_conf();
        cyc(1'b1, 4'b1111, CONF + 32'h0, 32'h0001_A5A5);
        checks++;
        if (led_out !== 16'hA5A5) begin
            errors++;
            $display("FAIL led_write got %h exp %h", led_out, 16'hA5A5);
        end
        cyc(1'b1, 4'b0000, CONF + 32'h0, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h0000_A5A5) begin
            errors++;
            $display("FAIL led_read got %h exp %h", data_sram_rdata, 32'h0000_A5A5);
        end
        cyc(1'b1, 4'b0000, CONF + 32'h20, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL unknown_off_read got %h exp %h", data_sram_rdata, 32'h0);
        end
        // Unknown-offset write must not disturb LED.
        cyc(1'b1, 4'b1111, CONF + 32'h20, 32'hFFFF_FFFF);
        checks++;
        if (led_out !== 16'hA5A5) begin
            errors++;
            $display("FAIL unknown_off_write got %h exp %h", led_out, 16'hA5A5);
        end
        cyc(1'b1, 4'b1111, CONF + 32'h4, 32'h1234_5678);
        cyc(1'b1, 4'b0010, CONF + 32'h4, 32'hFFFF_FFFF);
        cyc(1'b1, 4'b0000, CONF + 32'h4, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h1234_FF78) begin
            errors++;
            $display("FAIL scratch_lanes got %h exp %h", data_sram_rdata, 32'h1234_FF78);
        end
        // LED byte lane 0 only.
        cyc(1'b1, 4'b0001, CONF + 32'h0, 32'h0000_0033);
        checks++;
        if (led_out !== 16'hA533) begin
            errors++;
            $display("FAIL led_lane got %h exp %h", led_out, 16'hA533);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 4'b1111, 32'h0000_0040, 32'hCAFE_F00D);
        cyc(1'b1, 4'b0000, 32'h0000_0040, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b2b_ram got %h exp %h", data_sram_rdata, 32'hCAFE_F00D);
        end
        cyc(1'b1, 4'b0000, CONF + 32'h4, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h1234_FF78) begin
            errors++;
            $display("FAIL b2b_conf got %h exp %h", data_sram_rdata, 32'h1234_FF78);
        end
        cyc(1'b1, 4'b0000, 32'h0000_0040, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b2b_ram_again got %h exp %h", data_sram_rdata, 32'hCAFE_F00D);
        end
        idle();
        idle();
        checks++;
        if (data_sram_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL idle_hold got %h exp %h", data_sram_rdata, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_timer();
        logic [31:0] t1;
        logic [31:0] t2;
        cyc(1'b1, 4'b0000, CONF + 32'h8, 32'h0);
        t1 = data_sram_rdata;
        repeat (4) idle();
        // Timer writes are ignored (or hit an unknown offset); either way no effect.
        cyc(1'b1, 4'b0000, CONF + 32'h8, 32'h0);
        t2 = data_sram_rdata;
`ifdef DSRAM_TIMER_EN
        checks++;
        if (t2 - t1 !== 32'd5) begin
            errors++;
            $display("FAIL timer_delta got %0d exp %0d", t2 - t1, 5);
        end
`else
        checks++;
        if (t1 !== 32'h0) begin
            errors++;
            $display("FAIL timer_off_read1 got %h exp %h", t1, 32'h0);
        end
        checks++;
        if (t2 !== 32'h0) begin
            errors++;
            $display("FAIL timer_off_read2 got %h exp %h", t2, 32'h0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 4'b0000, CONF + 32'h4, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h1234_FF78) begin
            errors++;
            $display("FAIL pre_reset_read got %h exp %h", data_sram_rdata, 32'h1234_FF78);
        end
        // Reset asserted while a request is still being presented.
        data_sram_addr = 32'h0000_0040;
        resetn = 1'b0;
        #1;
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_rdata got %h exp %h", data_sram_rdata, 32'h0);
        end
        checks++;
        if (led_out !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_led got %h exp %h", led_out, 16'h0);
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        idle();
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL after_reset_idle got %h exp %h", data_sram_rdata, 32'h0);
        end
        cyc(1'b1, 4'b0000, 32'h0000_0040, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL ram_survives_reset got %h exp %h", data_sram_rdata, 32'hCAFE_F00D);
        end
        cyc(1'b1, 4'b0000, CONF + 32'h4, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL scratch_reset got %h exp %h", data_sram_rdata, 32'h0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ram_rw();
        test_byte_lanes();
        test_read_first();
        test_conf();
        test_back_to_back();
        test_timer();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
